seven_seg_scan: RTL and testbench

Parametrised multiplexed seven-segment scanner, next generation of the 4-digit driver. It drives NUMCELLS digits from one clock-divided scan with per-slot ghost blanking. A one-deep valid/ready shadow buffer lets the producer update all digits tear-free at frame boundaries. An optional PWM brightness control is available. It sits between the display-value logic and the board's segment/digit pins.

---
 rtl/seven_seg_scan.sv | 140 ++++++++++++++
 tb/tb_seven_seg_scan.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan.sv
// seven_seg_scan: multiplexed seven-segment scanner with tear-free shadow
// buffer and slot ghost blanking; optional PWM dimming via SEVENSEG_DIM_EN.
// Ports: clock, reset_n (sync, active-low); cellvalin/in_valid/in_ready load
// a full frame of segment patterns; brightness sets PWM duty (dim build only);
// dig/seg drive the display pins; frame_start pulses after each frame boundary.
module seven_seg_scan #(
  parameter int NUMCELLS       = 4,
  parameter int SEG_W          = 8,
  parameter int DIV            = 1024,
  parameter int BLANK          = 16,
  parameter int DIG_ACTIVE_LOW = 1
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [SEG_W*NUMCELLS-1:0] cellvalin,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [3:0]                brightness,
  output logic [NUMCELLS-1:0]       dig,
  output logic [SEG_W-1:0]          seg,
  output logic                      frame_start
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (NUMCELLS > 1) ? $clog2(NUMCELLS) : 1;
  localparam int AW = SEG_W * NUMCELLS;

  localparam logic [PW-1:0] PLAST = PW'(DIV - 1);
  localparam logic [IW-1:0] ILAST = IW'(NUMCELLS - 1);
  localparam logic [NUMCELLS-1:0] DIG_OFF =
    (DIG_ACTIVE_LOW != 0) ? '1 : '0;

  logic [PW-1:0]       pcnt_q, pcnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [AW-1:0]       act_q, act_d;
  logic [AW-1:0]       shadow_q, shadow_d;
  logic                pending_q, pending_d;
  logic                rdy_q;
  logic [NUMCELLS-1:0] dig_q, dig_d;
  logic [SEG_W-1:0]    seg_q, seg_d;
  logic                fs_q;

  logic                slot_end;
  logic                bound;
  logic                accept;
  logic                gate;
  logic                en;
  logic [NUMCELLS-1:0] onehot;
  logic [SEG_W-1:0]    seg_sel;

`ifdef SEVENSEG_DIM_EN
  logic [3:0] pwm_q;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pwm_q <= 4'd0;
    end else begin
      pwm_q <= pwm_q + 4'd1;
    end
  end

  assign gate = (brightness == 4'hF) || (pwm_q < brightness);
`else
  logic unused_brightness;
  assign unused_brightness = ^brightness;
  assign gate = 1'b1;
`endif

  assign slot_end = (pcnt_q == PLAST);
  assign bound    = slot_end && (idx_q == '0);
  assign accept   = in_valid && rdy_q;
  assign en       = (int'(pcnt_q) >= BLANK) && gate;

  always_comb begin
    pcnt_d = slot_end ? '0 : pcnt_q + PW'(1);
    idx_d  = idx_q;
    if (slot_end) begin
      idx_d = (idx_q == '0) ? ILAST : idx_q - IW'(1);
    end
  end

  // Consume the shadow at the boundary before looking at a new transfer;
  // a transfer can only land when pending is clear, so they never collide.
  always_comb begin
    act_d     = act_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    if (bound && pending_q) begin
      act_d     = shadow_q;
      pending_d = 1'b0;
    end
    if (accept) begin
      shadow_d  = cellvalin;
      pending_d = 1'b1;
    end
  end

  always_comb begin
    onehot  = '0;
    seg_sel = '0;
    for (int i = 0; i < NUMCELLS; i++) begin
      if (idx_q == IW'(i)) begin
        onehot[i] = 1'b1;
        seg_sel   = act_q[SEG_W*i +: SEG_W];
      end
    end
    dig_d = en ? (onehot ^ DIG_OFF) : DIG_OFF;
    seg_d = en ? seg_sel : '0;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pcnt_q    <= '0;
      idx_q     <= ILAST;
      act_q     <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
      rdy_q     <= 1'b1;
      dig_q     <= DIG_OFF;
      seg_q     <= '0;
      fs_q      <= 1'b0;
    end else begin
      pcnt_q    <= pcnt_d;
      idx_q     <= idx_d;
      act_q     <= act_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      rdy_q     <= ~pending_d;
      dig_q     <= dig_d;
      seg_q     <= seg_d;
      fs_q      <= bound;
    end
  end

  assign in_ready    = rdy_q;
  assign dig         = dig_q;
  assign seg         = seg_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// tb_seven_seg_scan: scoreboard bench for seven_seg_scan.
// Time-based reference model predicts every output cycle.
module tb_seven_seg_scan;

  localparam int N  = 4;
  localparam int SW = 8;
  localparam int W  = N * SW;
`ifdef SEVENSEG_DIM_EN
  localparam int DIV   = 64;
  localparam int BLANK = 0;
`else
  localparam int DIV   = 8;
  localparam int BLANK = 2;
`endif
  localparam int F = N * DIV;
  localparam logic [N-1:0] OFF = '1;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] cellvalin = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   brightness = 4'hF;
  logic [N-1:0] dig;
  logic [SW-1:0] seg;
  logic         frame_start;

  seven_seg_scan #(
    .NUMCELLS(N), .SEG_W(SW), .DIV(DIV),
    .BLANK(BLANK), .DIG_ACTIVE_LOW(1)
  ) dut (
    .clock(clk), .reset_n(reset_n),
    .cellvalin(cellvalin), .in_valid(in_valid),
    .in_ready(in_ready), .brightness(brightness),
    .dig(dig), .seg(seg), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            cyc;
    logic [N-1:0]  dig;
    logic [SW-1:0] seg;
    logic          fs;
    logic          rdy;
  } exp_t;

  exp_t q[$];
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  // model: cycles since reset release, displayed frame, shadow, pending
  int           m_tc = 0;
  logic [W-1:0] m_act = '0;
  logic [W-1:0] m_sh = '0;
  logic         m_pend = 1'b0;

  task automatic chk(input string nm, input int c,
                     input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h, want %h", nm, c, got, want);
    end
  endtask

  task automatic drive(input logic rst, input logic v,
                       input logic [W-1:0] d, input logic [3:0] br);
    exp_t e;
    int pos, idx;
    logic en, gate, acc;
    logic [N-1:0] oh;
    @(negedge clk);
    cyc++;
    reset_n = rst; in_valid = v; cellvalin = d; brightness = br;
    e.cyc = cyc;
    if (!rst) begin
      e.dig = OFF; e.seg = '0; e.fs = 1'b0; e.rdy = 1'b1;
      m_tc = 0; m_act = '0; m_sh = '0; m_pend = 1'b0;
    end else begin
      pos = m_tc % DIV;
      idx = N - 1 - ((m_tc / DIV) % N);
`ifdef SEVENSEG_DIM_EN
      gate = (br == 4'hF) || ((m_tc % 16) < int'(br));
`else
      gate = 1'b1;
`endif
      en = (pos >= BLANK) && gate;
      oh = '0;
      oh[idx] = 1'b1;
      e.dig = en ? ~oh : OFF;
      e.seg = en ? m_act[SW*idx +: SW] : '0;
      e.fs  = (pos == DIV - 1) && (idx == 0);
      acc = v && !m_pend;
      if (e.fs && m_pend) begin
        m_act = m_sh;
        m_pend = 1'b0;
      end
      if (acc) begin
        m_sh = d;
        m_pend = 1'b1;
      end
      m_tc++;
      e.rdy = !m_pend;
    end
    q.push_back(e);
  endtask

  task automatic idle(input int n, input logic [3:0] br);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, $urandom, br);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("dig", e.cyc, 32'(dig), 32'(e.dig));
        chk("seg", e.cyc, 32'(seg), 32'(e.seg));
        chk("frame_start", e.cyc, 32'(frame_start), 32'(e.fs));
        chk("in_ready", e.cyc, 32'(in_ready), 32'(e.rdy));
      end
    end
  end

  initial begin : stim
    int fs_at;
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, '0, 4'hF);
    // release, then measure first frame_start directly as well
    fs_at = -1;
    for (int i = 1; i <= F + 8; i++) begin
      drive(1'b1, 1'b0, '0, 4'hF);
      @(posedge clk); #2;
      if (fs_at < 0 && frame_start) fs_at = i;
    end
    chk("first_frame_start", cyc, 32'(fs_at), 32'(F));
    // single load
    drive(1'b1, 1'b1, 32'h3F06_5B4F, 4'hF);
    idle(3 * F, 4'hF);
    // mid-frame tear-free update
    idle(F / 2 + 3, 4'hF);
    drive(1'b1, 1'b1, $urandom, 4'hF);
    idle(2 * F + 5, 4'hF);
    // continuous valid, changing data
    for (int i = 0; i < 4 * F; i++) drive(1'b1, 1'b1, $urandom, 4'hF);
    idle(F, 4'hF);
    // reset in slot 2 with data pending
    for (int i = 0; i < F && ((m_tc / DIV) % N) != 1; i++)
      drive(1'b1, 1'b0, '0, 4'hF);
    drive(1'b1, 1'b1, 32'hA5A5_A5A5, 4'hF);
    drive(1'b1, 1'b0, '0, 4'hF);
    drive(1'b0, 1'b0, '0, 4'hF);
    drive(1'b0, 1'b0, '0, 4'hF);
    idle(2 * F + 4, 4'hF);
    // brightness levels
    drive(1'b1, 1'b1, 32'h3F06_5B4F, 4'd4);
    idle(2 * F, 4'd4);
    idle(F, 4'd0);
    idle(F, 4'hF);
    // random traffic with occasional reset
    for (int i = 0; i < 6 * F; i++)
      drive(($urandom % 300) != 0, ($urandom % 4) == 0,
            $urandom, 4'($urandom));
    @(posedge clk); #3;
    chk("scoreboard_drained", cyc, 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
